// File: rtl/card_deck_if.sv
// Handshake bundle between the card deck and the blackjack game FSM.
// The game FSM drives SHUFFLE/card_used; the deck presents the card.
interface card_deck_if;
  logic       SHUFFLE;
  logic       card_used;
  logic       RDY;
  logic [5:0] CARD;
  logic [4:0] VALUE;
  logic       EMPTY;
  logic [5:0] REMAIN;

  modport master (
    output SHUFFLE, card_used,
    input  RDY, CARD, VALUE, EMPTY, REMAIN
  );

  modport slave (
    input  SHUFFLE, card_used,
    output RDY, CARD, VALUE, EMPTY, REMAIN
  );
endinterface

// File: rtl/card_deck.sv
// Single 52-card deck: picks the next undealt card by probing from an
// LFSR-derived start position, presents it with RDY, and retires it when
// the game FSM pulses card_used. SHUFFLE returns every card to the deck.
module card_deck #(
  parameter logic [7:0] SEED       = 8'hA5,
  parameter bit         SEQUENTIAL = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  card_deck_if.slave deck
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SEEK,
    S_READY,
    S_EMPTY
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [5:0]  ptr_q, ptr_d;
  logic [5:0]  card_q, card_d;
  logic [5:0]  remain_q, remain_d;
  logic [51:0] used_q, used_d;
  logic        rdy_q, empty_q;
  logic [5:0]  start_ptr;
  logic [5:0]  rank;
  logic [4:0]  value;

  // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1; free-running in every state.
  assign lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign start_ptr = SEQUENTIAL ? 6'd0 : 6'(lfsr_q % 8'd52);

  // Next-state logic; SHUFFLE overrides everything, including a card_used.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    card_d   = card_q;
    remain_d = remain_q;
    used_d   = used_q;
    if (deck.SHUFFLE) begin
      state_d  = S_LOAD;
      used_d   = '0;
      remain_d = 6'd52;
    end else begin
      case (state_q)
        S_LOAD: begin
          ptr_d   = start_ptr;
          state_d = S_SEEK;
        end
        S_SEEK: begin
          if (!used_q[ptr_q]) begin
            card_d  = ptr_q;
            state_d = S_READY;
          end else begin
            ptr_d = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;
          end
        end
        S_READY: begin
          if (deck.card_used) begin
            used_d[card_q] = 1'b1;
            remain_d       = remain_q - 6'd1;
            state_d        = (remain_q == 6'd1) ? S_EMPTY : S_LOAD;
          end
        end
        S_EMPTY: begin
          state_d = S_EMPTY;
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end
  end

  // State and datapath registers; RDY/EMPTY are registered decodes of the next state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_LOAD;
      lfsr_q   <= SEED;
      ptr_q    <= '0;
      card_q   <= '0;
      remain_q <= 6'd52;
      used_q   <= '0;
      rdy_q    <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      ptr_q    <= ptr_d;
      card_q   <= card_d;
      remain_q <= remain_d;
      used_q   <= used_d;
      rdy_q    <= (state_d == S_READY);
      empty_q  <= (state_d == S_EMPTY);
    end
  end

  // Blackjack value of the presented card; soft-ace handling belongs to the scorer.
  always_comb begin
    rank = card_q % 6'd13;
    if (rank == 6'd0) begin
      value = 5'd11;
    end else if (rank <= 6'd9) begin
      value = 5'(rank) + 5'd1;
    end else begin
      value = 5'd10;
    end
  end

  assign deck.RDY    = rdy_q;
  assign deck.CARD   = card_q;
  assign deck.VALUE  = value;
  assign deck.EMPTY  = empty_q;
  assign deck.REMAIN = remain_q;

endmodule
